// File: rtl/mem_pkg.sv
// Shared types and default widths for the request/response memory.
package mem_pkg;

    localparam int DEF_ADDR_WIDTH = 5;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_READ_LAT   = 1;

    typedef enum logic [1:0] {OP_NOP, OP_READ, OP_WRITE, OP_CLEAR} mem_op_e;

    typedef enum logic {S_IDLE, S_CLEAR} state_e;

endpackage

// File: rtl/rsp_fifo.sv
// In-order response buffer; head always shows the oldest stored entry.
module rsp_fifo #(
    parameter  int DATA_WIDTH = 8,
    parameter  int DEPTH      = 2,
    localparam int CW         = $clog2(DEPTH + 1),
    localparam int PW         = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic                  full,
    output logic                  empty,
    output logic [CW-1:0]         count,
    output logic [DATA_WIDTH-1:0] head
);

    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

    logic [DATA_WIDTH-1:0] store [DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
            if (pop)  rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) store[wr_ptr] <= push_data;
    end

    assign head  = store[rd_ptr];
    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));

endmodule

// File: rtl/mem_req_rsp.sv
// Single-port memory with valid/ready request and response channels,
// pipelined reads, an in-order response buffer and a sequenced CLEAR.
module mem_req_rsp
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = 2 ** ADDR_WIDTH,
    parameter int READ_LAT   = DEF_READ_LAT,
    parameter int RSP_DEPTH  = READ_LAT + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  mem_op_e               req_op,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  busy
);

    localparam int CW = $clog2(RSP_DEPTH + 1);
    localparam logic [ADDR_WIDTH:0]   DEPTH_W   = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   clr_addr_q;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic [READ_LAT-1:0]     pipe_v;
    logic [DATA_WIDTH-1:0]   pipe_d [READ_LAT];
    logic [CW-1:0]           in_flight;
    logic [CW-1:0]           buf_count;
    logic                    buf_full, buf_empty, buf_push, buf_pop;
    logic [DATA_WIDTH-1:0]   buf_head;
    logic                    accept, addr_ok, rd_launch;
    logic [DATA_WIDTH-1:0]   rd_word;
    logic                    mem_we;
    logic [ADDR_WIDTH-1:0]   mem_wa;
    logic [DATA_WIDTH-1:0]   mem_wd;
    logic                    tail_v;
    logic [DATA_WIDTH-1:0]   tail_d;

    // Both channels: a transfer happens on a posedge where valid && ready;
    // the producer holds its payload stable until that edge.
    assign accept    = req_valid && req_ready;
    assign addr_ok   = ({1'b0, req_addr} < DEPTH_W);
    assign rd_launch = accept && (req_op == OP_READ);
    assign rd_word   = addr_ok ? mem[req_addr] : '0;

    always_comb begin
        in_flight = '0;
        for (int i = 0; i < READ_LAT; i++) in_flight = in_flight + CW'(pipe_v[i]);
    end

    // Every read in the pipe or the buffer holds a credit, so the buffer cannot overflow.
    always_comb begin
        req_ready = 1'b0;
        if (!rst && state_q == S_IDLE) begin
            case (req_op)
                OP_READ:  req_ready = (in_flight + buf_count) < CW'(RSP_DEPTH);
                OP_CLEAR: req_ready = (in_flight == '0) && (buf_count == '0);
                default:  req_ready = 1'b1;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept && req_op == OP_CLEAR) state_d = S_CLEAR;
            S_CLEAR: if (clr_addr_q == LAST_ADDR) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            clr_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= (state_q == S_CLEAR) ? clr_addr_q + 1'b1 : '0;
        end
    end

    // The rst gate leaves the word under the clear pointer untouched on an abort.
    assign mem_we = !rst && ((state_q == S_CLEAR) ||
                             (accept && req_op == OP_WRITE && addr_ok));
    assign mem_wa = (state_q == S_CLEAR) ? clr_addr_q : req_addr;
    assign mem_wd = (state_q == S_CLEAR) ? '0 : req_wdata;

    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_wa] <= mem_wd;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_v <= '0;
        end else begin
            pipe_v[0] <= rd_launch;
            for (int i = 1; i < READ_LAT; i++) pipe_v[i] <= pipe_v[i-1];
        end
    end

    always_ff @(posedge clk) begin
        pipe_d[0] <= rd_word;
        for (int i = 1; i < READ_LAT; i++) pipe_d[i] <= pipe_d[i-1];
    end

    assign tail_v = pipe_v[READ_LAT-1];
    assign tail_d = pipe_d[READ_LAT-1];

    // The tail bypasses the buffer only when nothing older is waiting and it is taken now.
    assign buf_pop  = !buf_empty && rsp_ready;
    assign buf_push = tail_v && !(buf_empty && rsp_ready) && !buf_full;

    rsp_fifo #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (buf_push),
        .push_data(tail_d),
        .pop      (buf_pop),
        .full     (buf_full),
        .empty    (buf_empty),
        .count    (buf_count),
        .head     (buf_head)
    );

    assign rsp_valid = !buf_empty || tail_v;
    assign rsp_data  = !buf_empty ? buf_head : (tail_v ? tail_d : '0);
    assign busy      = (state_q == S_CLEAR);

endmodule
